// File: rtl/prga_fifo.sv
// ---------------------------------------------------------------------------
// prga_fifo
//
// Synchronous single-clock FIFO built on a circular array. The read and write
// pointers carry one extra MSB so that "full" and "empty" can be told apart
// once the pointers wrap.
//
// Two read styles are selected by LOOKAHEAD:
//   LOOKAHEAD = 0 : standard read. An accepted rd loads dout at that edge with
//                   the word at the read pointer; dout holds otherwise.
//   LOOKAHEAD = 1 : first-word-fall-through. A one-word lookahead register
//                   holds the head word with a valid flag; dout shows it and
//                   rd pops it. Capacity is 2^DEPTH_LOG2 + 1 words, and full
//                   reflects the array only.
//
// Ports
//   clk    in   1           rising-edge clock for all state
//   rst    in   1           asynchronous reset, active low
//   full   out  1           no further word can be accepted
//   wr     in   1           write request
//   din    in   DATA_WIDTH  write data, captured with wr
//   empty  out  1           no word available to read
//   rd     in   1           read request (LOOKAHEAD=0) / pop (LOOKAHEAD=1)
//   dout   out  DATA_WIDTH  read data
// ---------------------------------------------------------------------------
module prga_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int LOOKAHEAD  = 0,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  full,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  empty,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam bit LA    = (LOOKAHEAD != 0);

    // Pointer difference that means "array holds DEPTH words": MSBs differ,
    // index bits equal.
    localparam logic [PW-1:0] WRAP_DIFF = {1'b1, {DEPTH_LOG2{1'b0}}};

    // Storage array (contents are intentionally never reset)
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Stage 0: array pointers
    logic [PW-1:0]         wptr_p0;
    logic [PW-1:0]         rptr_p0;

    // Stage 1: delayed write pointer, output / lookahead register and valid
    logic [PW-1:0]         wptr_p1;
    logic [DATA_WIDTH-1:0] dout_p1;
    logic                  vld_p1;

    logic                  arr_full;
    logic                  arr_empty;
    logic                  arr_avail;
    logic                  wr_en;
    logic                  arr_rd;
    logic                  pop;

    // Flag / handshake decode, all from the pre-edge state
    always_comb begin
        arr_full  = ((wptr_p0 ^ rptr_p0) == WRAP_DIFF);
        arr_empty = (wptr_p0 == rptr_p0);
        // In lookahead mode a word only becomes fetchable one edge after it
        // was written (compare against the delayed write pointer). Because
        // wptr_p1 never runs ahead of wptr_p0, this can never over-read.
        arr_avail = (wptr_p1 != rptr_p0);

        // Gating with rst keeps the array untouched while reset is held.
        wr_en     = rst && wr && !arr_full;

        pop       = 1'b0;
        arr_rd    = 1'b0;
        empty     = 1'b1;
        if (LA) begin
            // Refill the lookahead register when it is empty or being popped.
            pop    = rd && vld_p1;
            arr_rd = rst && arr_avail && (!vld_p1 || pop);
            empty  = !vld_p1;
        end else begin
            pop    = rd && !arr_empty;
            arr_rd = rst && pop;
            empty  = arr_empty;
        end

        full = arr_full;
        dout = dout_p1;
    end

    // Stage 0 -> array write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_p0[DEPTH_LOG2-1:0]] <= din;
        end
    end

    // Stage 0 -> stage 1: pointers, delayed write pointer, read register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_p0 <= '0;
            rptr_p0 <= '0;
            wptr_p1 <= '0;
            vld_p1  <= 1'b0;
            dout_p1 <= '0;
        end else begin
            wptr_p1 <= wptr_p0;

            if (wr_en) begin
                wptr_p0 <= wptr_p0 + PW'(1);
            end

            if (arr_rd) begin
                rptr_p0 <= rptr_p0 + PW'(1);
                dout_p1 <= mem[rptr_p0[DEPTH_LOG2-1:0]];
            end

            // A pop with a simultaneous refill keeps the register valid.
            if (arr_rd) begin
                vld_p1 <= 1'b1;
            end else if (pop) begin
                vld_p1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prga_fifo.sv
// ---------------------------------------------------------------------------
// tb_prga_fifo
//
// Directed bench for prga_fifo. Two instances share clock and reset:
//   u_la0 : LOOKAHEAD = 0 (standard read), DEPTH_LOG2 = 4
//   u_la1 : LOOKAHEAD = 1 (first-word-fall-through), DEPTH_LOG2 = 4
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_prga_fifo;

    logic       clk;
    logic       rst;

    logic       a_wr, a_rd, a_full, a_empty;
    logic [7:0] a_din, a_dout;
    logic       b_wr, b_rd, b_full, b_empty;
    logic [7:0] b_din, b_dout;

    int errors;
    int checks;

    prga_fifo #(.DATA_WIDTH(8), .LOOKAHEAD(0), .DEPTH_LOG2(4)) u_la0 (
        .clk   (clk),
        .rst   (rst),
        .full  (a_full),
        .wr    (a_wr),
        .din   (a_din),
        .empty (a_empty),
        .rd    (a_rd),
        .dout  (a_dout)
    );

    prga_fifo #(.DATA_WIDTH(8), .LOOKAHEAD(1), .DEPTH_LOG2(4)) u_la1 (
        .clk   (clk),
        .rst   (rst),
        .full  (b_full),
        .wr    (b_wr),
        .din   (b_din),
        .empty (b_empty),
        .rd    (b_rd),
        .dout  (b_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_wr = 0; a_rd = 0; a_din = 8'h00;
        b_wr = 0; b_rd = 0; b_din = 8'h00;
        #3 rst = 1'b0;
        tick();
        tick();
        checks++;
        if (a_empty !== 1'b1 || a_full !== 1'b0 || a_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_la0: empty=%b full=%b dout=%h, expected 1 0 00", a_empty, a_full, a_dout);
        end
        checks++;
        if (b_empty !== 1'b1 || b_full !== 1'b0 || b_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_la1: empty=%b full=%b dout=%h, expected 1 0 00", b_empty, b_full, b_dout);
        end
        // Writes presented while reset is held must be ignored
        a_wr = 1; a_din = 8'hEE; b_wr = 1; b_din = 8'hEE;
        tick();
        a_wr = 0; b_wr = 0;
        tick();
        tick();
        checks++;
        if (a_empty !== 1'b1 || b_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_write: la0 empty=%b la1 empty=%b, expected 1 1", a_empty, b_empty);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic_la0();
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            a_wr = 1; a_din = exp[i];
            tick();
            checks++;
            if (a_empty !== 1'b0) begin
                errors++;
                $display("FAIL basic_empty_after_wr%0d: empty=%b, expected 0", i, a_empty);
            end
        end
        a_wr = 0;
        for (int i = 0; i < 3; i++) begin
            a_rd = 1;
            tick();
            checks++;
            if (a_dout !== exp[i]) begin
                errors++;
                $display("FAIL basic_rd%0d: dout=%h, expected %h", i, a_dout, exp[i]);
            end
        end
        a_rd = 0;
        checks++;
        if (a_empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_empty_after_rd: empty=%b, expected 1", a_empty);
        end
        // Read while empty: ignored, dout holds last read value
        a_rd = 1;
        tick();
        a_rd = 0;
        checks++;
        if (a_dout !== 8'h33 || a_empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_rd_empty: dout=%h empty=%b, expected 33 1", a_dout, a_empty);
        end
    endtask

    task automatic test_fwft();
        b_wr = 1; b_din = 8'hA5;
        tick();
        b_wr = 0;
        checks++;
        if (b_empty !== 1'b1) begin
            errors++;
            $display("FAIL fwft_edge1: empty=%b, expected 1", b_empty);
        end
        tick();
        checks++;
        if (b_empty !== 1'b1) begin
            errors++;
            $display("FAIL fwft_edge2: empty=%b, expected 1", b_empty);
        end
        tick();
        checks++;
        if (b_empty !== 1'b0 || b_dout !== 8'hA5) begin
            errors++;
            $display("FAIL fwft_head: empty=%b dout=%h, expected 0 a5", b_empty, b_dout);
        end
        b_rd = 1;
        tick();
        b_rd = 0;
        checks++;
        if (b_empty !== 1'b1) begin
            errors++;
            $display("FAIL fwft_pop: empty=%b, expected 1", b_empty);
        end
    endtask

    task automatic test_full_la0();
        for (int i = 0; i < 16; i++) begin
            a_wr = 1; a_din = 8'(i);
            tick();
            if (i == 14) begin
                checks++;
                if (a_full !== 1'b0) begin
                    errors++;
                    $display("FAIL full_at15: full=%b, expected 0", a_full);
                end
            end
        end
        checks++;
        if (a_full !== 1'b1) begin
            errors++;
            $display("FAIL full_at16: full=%b, expected 1", a_full);
        end
        a_din = 8'hFF;
        tick();
        a_wr = 0;
        checks++;
        if (a_full !== 1'b1) begin
            errors++;
            $display("FAIL full_drop: full=%b, expected 1", a_full);
        end
        for (int i = 0; i < 16; i++) begin
            a_rd = 1;
            tick();
            checks++;
            if (a_dout !== 8'(i)) begin
                errors++;
                $display("FAIL full_rd%0d: dout=%h, expected %h", i, a_dout, 8'(i));
            end
        end
        checks++;
        if (a_empty !== 1'b1) begin
            errors++;
            $display("FAIL full_drained: empty=%b, expected 1", a_empty);
        end
        // One more read must not surface the dropped 0xFF
        tick();
        a_rd = 0;
        checks++;
        if (a_dout !== 8'h0F) begin
            errors++;
            $display("FAIL full_no_ff: dout=%h, expected 0f", a_dout);
        end
    endtask

    task automatic test_full_rw_la0();
        for (int i = 0; i < 16; i++) begin
            a_wr = 1; a_din = 8'h80 + 8'(i);
            tick();
        end
        a_din = 8'h55; a_rd = 1;
        tick();
        a_wr = 0;
        checks++;
        if (a_dout !== 8'h80 || a_full !== 1'b0) begin
            errors++;
            $display("FAIL fullrw: dout=%h full=%b, expected 80 0", a_dout, a_full);
        end
        for (int i = 1; i < 16; i++) begin
            tick();
            checks++;
            if (a_dout !== 8'h80 + 8'(i)) begin
                errors++;
                $display("FAIL fullrw_rd%0d: dout=%h, expected %h", i, a_dout, 8'h80 + 8'(i));
            end
        end
        a_rd = 0;
        checks++;
        if (a_empty !== 1'b1) begin
            errors++;
            $display("FAIL fullrw_55_dropped: empty=%b, expected 1", a_empty);
        end
    endtask

    task automatic test_capacity_la1();
        for (int i = 0; i < 17; i++) begin
            b_wr = 1; b_din = 8'(i);
            tick();
            if (i == 15) begin
                checks++;
                if (b_full !== 1'b0) begin
                    errors++;
                    $display("FAIL cap_at16: full=%b, expected 0", b_full);
                end
            end
        end
        checks++;
        if (b_full !== 1'b1) begin
            errors++;
            $display("FAIL cap_at17: full=%b, expected 1", b_full);
        end
        b_din = 8'hFF;
        tick();
        b_wr = 0;
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (b_empty !== 1'b0 || b_dout !== 8'(i)) begin
                errors++;
                $display("FAIL cap_head%0d: empty=%b dout=%h, expected 0 %h", i, b_empty, b_dout, 8'(i));
            end
            b_rd = 1;
            tick();
        end
        b_rd = 0;
        checks++;
        if (b_empty !== 1'b1) begin
            errors++;
            $display("FAIL cap_drained: empty=%b, expected 1", b_empty);
        end
    endtask

    task automatic test_back_to_back_la0();
        // Streaming write with a concurrent read one word behind; wraps twice
        for (int k = 0; k < 40; k++) begin
            a_wr = 1; a_din = 8'(k); a_rd = (k > 0);
            tick();
            if (k > 0) begin
                checks++;
                if (a_dout !== 8'(k - 1)) begin
                    errors++;
                    $display("FAIL wrap0_%0d: dout=%h, expected %h", k - 1, a_dout, 8'(k - 1));
                end
            end
        end
        a_wr = 0; a_rd = 1;
        tick();
        a_rd = 0;
        checks++;
        if (a_dout !== 8'd39 || a_empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap0_last: dout=%h empty=%b, expected 27 1", a_dout, a_empty);
        end
    endtask

    task automatic test_wrap_la1();
        for (int i = 0; i < 40; i++) begin
            b_wr = 1; b_din = 8'(i);
            tick();
            b_wr = 0;
            tick();
            tick();
            checks++;
            if (b_empty !== 1'b0 || b_dout !== 8'(i)) begin
                errors++;
                $display("FAIL wrap1_%0d: empty=%b dout=%h, expected 0 %h", i, b_empty, b_dout, 8'(i));
            end
            b_rd = 1;
            tick();
            b_rd = 0;
        end
        checks++;
        if (b_empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap1_drained: empty=%b, expected 1", b_empty);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            a_wr = 1; a_din = 8'h40 + 8'(i);
            b_wr = 1; b_din = 8'h40 + 8'(i);
            tick();
        end
        a_wr = 0; b_wr = 0;
        tick();
        checks++;
        if (a_empty !== 1'b0 || b_empty !== 1'b0 || b_dout !== 8'h40) begin
            errors++;
            $display("FAIL rstmid_pre: la0 empty=%b la1 empty=%b la1 dout=%h, expected 0 0 40", a_empty, b_empty, b_dout);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (a_empty !== 1'b1 || a_full !== 1'b0 || a_dout !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_la0: empty=%b full=%b dout=%h, expected 1 0 00", a_empty, a_full, a_dout);
        end
        checks++;
        if (b_empty !== 1'b1 || b_full !== 1'b0 || b_dout !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_la1: empty=%b full=%b dout=%h, expected 1 0 00", b_empty, b_full, b_dout);
        end
        a_wr = 1; a_din = 8'hEE; b_wr = 1; b_din = 8'hEE;
        tick();
        rst = 1'b1;
        a_wr = 0; b_wr = 0;
        tick();
        a_wr = 1; a_din = 8'h99; b_wr = 1; b_din = 8'h77;
        tick();
        a_wr = 0; b_wr = 0;
        a_rd = 1;
        tick();
        a_rd = 0;
        checks++;
        if (a_dout !== 8'h99 || a_empty !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after_la0: dout=%h empty=%b, expected 99 1", a_dout, a_empty);
        end
        tick();
        checks++;
        if (b_dout !== 8'h77 || b_empty !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after_la1: dout=%h empty=%b, expected 77 0", b_dout, b_empty);
        end
        b_rd = 1;
        tick();
        b_rd = 0;
        checks++;
        if (b_empty !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_la1_only_new: empty=%b, expected 1", b_empty);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic_la0();
        test_fwft();
        test_full_la0();
        test_full_rw_la0();
        test_capacity_la1();
        test_back_to_back_la0();
        test_wrap_la1();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prga_fifo.md
PRGA_FIFO -- requirements
Module: prga_fifo

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset (clock `clk`, reset `rst`).
REQ-002 Parameter `DATA_WIDTH`, default 8: width of each data word.
REQ-003 Parameter `LOOKAHEAD`, default 0: 0 = standard read (data appears after rd); 1 = first-word-fall-through (head word presented on dout).
REQ-004 Parameter `DEPTH_LOG2`, default 4: storage array holds 2^DEPTH_LOG2 words.
REQ-005 `clk`  in  1  rising-edge clock for all state.
REQ-006 `rst`  in  1  asynchronous reset, active low.
REQ-007 `full`  out  1  high when no further word can be accepted.
REQ-008 `wr`  in  1  write request, sampled on the rising clock edge.
REQ-009 `din`  in  DATA_WIDTH  write data, captured with wr.
REQ-010 `empty`  out  1  high when no word is available to read.
REQ-011 `rd`  in  1  read request (LOOKAHEAD=0) or pop/acknowledge (LOOKAHEAD=1).
REQ-012 `dout`  out  DATA_WIDTH  read data.

Function
REQ-013 Storage is a circular array with read and write pointers of DEPTH_LOG2+1 bits; the extra MSB distinguishes full from empty at pointer wrap-around.
REQ-014 An accepted write (wr && !full) stores din at the write pointer and increments it modulo 2^(DEPTH_LOG2+1); writes while full are dropped with no state change.
REQ-015 An accepted read (rd && !empty) increments the read pointer; reads while empty are ignored with no state change.
REQ-016 Simultaneous wr and rd in one cycle are both honoured when each is individually legal; full and empty are evaluated on the pre-edge state.
REQ-017 LOOKAHEAD=0: on an accepted read, dout is loaded at that edge with the word at the read pointer; otherwise dout holds its value.
REQ-018 LOOKAHEAD=0: empty deasserts in the cycle after the first accepted write edge; full asserts when the array holds 2^DEPTH_LOG2 words.
REQ-019 LOOKAHEAD=1: the core array feeds an internal one-word lookahead register that holds the head word and a valid flag.
REQ-020 The lookahead register fills automatically from the array whenever it is invalid, or is being popped, and the array is non-empty.
REQ-021 LOOKAHEAD=1: `empty` = !valid; `dout` = lookahead register contents; `rd && !empty` pops the head and, when the array is non-empty, loads the next word at the same edge.
REQ-022 LOOKAHEAD=1: the first word written into an empty FIFO appears on dout with empty low two edges after the write edge.
REQ-023 LOOKAHEAD=1: total capacity is 2^DEPTH_LOG2+1 words; full reflects the array only.
REQ-024 dout when empty: in LOOKAHEAD=0 it holds the last read value; in LOOKAHEAD=1 it holds the last popped value and is don't-care for checking.

Reset
REQ-025 While rst is low: pointers = 0, lookahead valid = 0, dout = 0, empty = 1, full = 0; array contents are not reset.
REQ-026 Reset asserted mid-operation discards all stored words immediately; no write or read is accepted while rst is low.
REQ-027 After rst deasserts, the first rising edge may accept a write.

Verification
REQ-028 LOOKAHEAD=0, reset, write 0x11,0x22,0x33 on consecutive edges, then rd for 3 cycles -> dout = 0x11,0x22,0x33 one edge after each rd; empty = 1 after the third read.
REQ-029 LOOKAHEAD=1, write 0xA5 into an empty FIFO -> empty low and dout = 0xA5 two edges later; pulse rd -> empty = 1 next cycle.
REQ-030 DEPTH_LOG2=4, LOOKAHEAD=0, write 0x00..0x0F -> full = 1 after 16th write; 17th write 0xFF dropped; 16 reads return 0x00..0x0F in order.
REQ-031 Full FIFO, assert wr (0x55) and rd together -> read accepted, write dropped; next cycle full = 0.
REQ-032 Pointer wrap: 40 interleaved write/read pairs with data = index -> output sequence 0..39 without loss or duplication in both LOOKAHEAD modes.
REQ-033 Assert rst mid-stream with 5 words stored -> empty = 1, full = 0, dout = 0 immediately; subsequent reads return only data written after reset.
